// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared encodings and helpers for the divider issue controller
//
// Purpose : op encodings, FSM state codes, special-case result constants and
//           the divide-by-zero / signed-overflow short-circuit helper.
// Ports   : none (package).
package div_ctrl_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ISSUE = 3'd1;
  localparam state_t ST_GUARD = 3'd2;
  localparam state_t ST_WAIT  = 3'd3;
  localparam state_t ST_RESP  = 3'd4;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;
  localparam logic [31:0] MINUS_ONE     = 32'hFFFF_FFFF;

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  // Bit 32 flags that the divider can be skipped; bits 31:0 hold the result.
  function automatic logic [32:0] special_result(input logic [1:0]  op,
                                                 input logic [31:0] a,
                                                 input logic [31:0] b);
    logic [32:0] res;
    res = '0;
    if (b == '0) begin
      res = {1'b1, (is_rem_op(op) ? a : DIV_BY_ZERO_Q)};
    end else if (is_signed_op(op) && (a == INT_MIN) && (b == MINUS_ONE)) begin
      res = {1'b1, (is_rem_op(op) ? 32'h0 : INT_MIN)};
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter picking the first request at or after a pointer
//
// Purpose : combinational grant of the first asserted request found when
//           scanning upward (with wrap) from ptr; nothing granted unless en.
// Ports   : req[NREQ]   request vector
//           en          allow a grant this cycle
//           ptr[IDW]    highest-priority index
//           gnt[NREQ]   one-hot grant (or zero)
//           gnt_idx     index of the granted request
//           gnt_valid   a grant was made
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_valid
);

  // Scan offsets from farthest to nearest so the nearest request wins.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    if (en) begin
      for (int off = NREQ - 1; off >= 0; off--) begin
        for (int j = 0; j < NREQ; j++) begin
          if (req[j] && (j == ((int'(ptr) + off) % NREQ))) begin
            gnt       = '0;
            gnt[j]    = 1'b1;
            gnt_idx   = IDW'(j);
            gnt_valid = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - shares one iterative divider between NREQ requesters
//
// Purpose : round-robin grants DIV/DIVU/REM/REMU requests, short-circuits
//           divide-by-zero and signed overflow, runs the divider start/busy
//           handshake and returns one tagged result on a valid/ready port.
// Ports   : req_valid/req_ready/req_op/req_a/req_b/req_tag  per-requester request
//           rsp_valid/rsp_ready/rsp_data/rsp_id/rsp_tag      result port
//           div_start/div_signed/div_a/div_b                 divider command
//           div_busy/div_q/div_r                             divider status/result
module div_issue_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int TAG_W       = 5,
  parameter int START_GUARD = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [32*NREQ-1:0]      req_a,
  input  logic [32*NREQ-1:0]      req_b,
  input  logic [TAG_W*NREQ-1:0]   req_tag,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_data,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [TAG_W-1:0]        rsp_tag,
  output logic                    div_start,
  output logic                    div_signed,
  output logic [31:0]             div_a,
  output logic [31:0]             div_b,
  input  logic                    div_busy,
  input  logic [31:0]             div_q,
  input  logic [31:0]             div_r
);

  localparam int IDW = $clog2(NREQ);
  localparam int GW  = (START_GUARD > 1) ? $clog2(START_GUARD) : 1;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [1:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic             signed_q, signed_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [GW-1:0]    guard_cnt_q, guard_cnt_d;

  logic             arb_en;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_valid;
  logic [1:0]       sel_op;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic [TAG_W-1:0] sel_tag;
  logic [32:0]      spec_res;

  // A busy divider after reset may still be finishing a discarded op.
  assign arb_en = (state_q == ST_IDLE) && !div_busy && !reset;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req       (req_valid),
    .en        (arb_en),
    .ptr       (rr_ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // One-hot mux of the granted requester's fields.
  always_comb begin
    sel_op  = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_tag = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_op  = req_op[2*i +: 2];
        sel_a   = req_a[32*i +: 32];
        sel_b   = req_b[32*i +: 32];
        sel_tag = req_tag[TAG_W*i +: TAG_W];
      end
    end
    spec_res = special_result(sel_op, sel_a, sel_b);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      signed_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_tag_q   <= '0;
      guard_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      signed_q    <= signed_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_tag_q   <= rsp_tag_d;
      guard_cnt_q <= guard_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    signed_d    = signed_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_tag_d   = rsp_tag_q;
    guard_cnt_d = guard_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          op_d      = sel_op;
          a_d       = sel_a;
          b_d       = sel_b;
          signed_d  = is_signed_op(sel_op);
          rsp_id_d  = gnt_idx;
          rsp_tag_d = sel_tag;
          rr_ptr_d  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
          if (spec_res[32]) begin
            rsp_data_d = spec_res[31:0];
            state_d    = ST_RESP;
          end else begin
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        guard_cnt_d = '0;
        state_d     = (START_GUARD == 0) ? ST_WAIT : ST_GUARD;
      end
      // div_busy may lag div_start, so it is ignored for START_GUARD cycles.
      ST_GUARD: begin
        if (guard_cnt_q == GW'(START_GUARD - 1)) begin
          state_d = ST_WAIT;
        end else begin
          guard_cnt_d = guard_cnt_q + GW'(1);
        end
      end
      ST_WAIT: begin
        if (!div_busy) begin
          rsp_data_d = is_rem_op(op_q) ? div_r : div_q;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = gnt;
    rsp_valid  = (state_q == ST_RESP);
    div_start  = (state_q == ST_ISSUE);
    div_signed = signed_q;
    div_a      = a_q;
    div_b      = b_q;
    rsp_data   = rsp_data_q;
    rsp_id     = rsp_id_q;
    rsp_tag    = rsp_tag_q;
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - self-checking bench for div_issue_ctrl
module tb_div_issue_ctrl;
  import div_ctrl_pkg::*;

  localparam int NREQ  = 2;
  localparam int TAG_W = 5;
  localparam int SG    = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op;
  logic [32*NREQ-1:0]    req_a;
  logic [32*NREQ-1:0]    req_b;
  logic [TAG_W*NREQ-1:0] req_tag;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_data;
  logic [0:0]            rsp_id;
  logic [TAG_W-1:0]      rsp_tag;
  logic                  div_start;
  logic                  div_signed;
  logic [31:0]           div_a;
  logic [31:0]           div_b;
  logic                  div_busy;
  logic [31:0]           div_q;
  logic [31:0]           div_r;

  logic                  r_v   [NREQ];
  logic [1:0]            r_op  [NREQ];
  logic [31:0]           r_a   [NREQ];
  logic [31:0]           r_b   [NREQ];
  logic [TAG_W-1:0]      r_tag [NREQ];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_ptr = 0;
  int last_gid = 0;
  logic [31:0] last_data = '0;
  int gq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_valid[g]               = r_v[g];
    assign req_op[2*g +: 2]           = r_op[g];
    assign req_a[32*g +: 32]          = r_a[g];
    assign req_b[32*g +: 32]          = r_b[g];
    assign req_tag[TAG_W*g +: TAG_W]  = r_tag[g];
  end

  div_issue_ctrl #(.NREQ(NREQ), .TAG_W(TAG_W), .START_GUARD(SG)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_tag(rsp_tag),
    .div_start(div_start), .div_signed(div_signed), .div_a(div_a), .div_b(div_b),
    .div_busy(div_busy), .div_q(div_q), .div_r(div_r)
  );

  // RISC-V style division arithmetic, used for both the divider model and the expectation.
  function automatic logic [31:0] div_calc(input logic s, input logic [31:0] a,
                                           input logic [31:0] b, input logic rem);
    if (b == 32'h0) return rem ? a : 32'hFFFF_FFFF;
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
    if (s) return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return rem ? a % b : a / b;
  endfunction

  // Divider model: busy rises two cycles after the start pulse (inside the
  // guard window), stays up model_lat+1 cycles, then q/r become valid.
  logic        m_run = 1'b0;
  int          m_t = 0;
  int          model_lat = 2;
  int          start_count = 0;
  logic [31:0] m_a = '0, m_b = '0, mq = '0, mr = '0;
  logic        m_s = 1'b0;
  assign div_busy = m_run && (m_t >= 2) && (m_t <= 2 + model_lat);
  assign div_q = mq;
  assign div_r = mr;

  always @(posedge clk) begin
    if (div_start) begin
      m_run <= 1'b1; m_t <= 1; m_a <= div_a; m_b <= div_b; m_s <= div_signed;
      start_count <= start_count + 1;
    end else if (m_run) begin
      if (m_t >= 2 + model_lat) begin
        m_run <= 1'b0;
        mq <= div_calc(m_s, m_a, m_b, 1'b0);
        mr <= div_calc(m_s, m_a, m_b, 1'b1);
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic set_req(input int id, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] tag);
    r_v[id] = 1'b1; r_op[id] = op; r_a[id] = a; r_b[id] = b; r_tag[id] = tag;
  endtask

  task automatic rand_req(input int id);
    logic [31:0] a, b;
    int sel;
    sel = $urandom_range(0, 7);
    a = $urandom;
    b = (sel == 0) ? 32'h0 : ((sel == 1) ? 32'($urandom_range(1, 300)) : $urandom);
    if (sel == 2) begin a = INT_MIN; b = 32'hFFFF_FFFF; end
    set_req(id, 2'($urandom_range(0, 3)), a, b, TAG_W'($urandom));
  endtask

  // Serves n_ops grants. Entry and exit are just after a falling edge.
  task automatic run_ops(input int n_ops, input int stall, input int refill_in);
    int refill, waited, exp_id, g, lat;
    logic special, sgn;
    logic [31:0] exp_res, hold_d;
    logic [TAG_W-1:0] exp_tag;
    int s0;
    refill = refill_in;
    for (int k = 0; k < n_ops; k++) begin
      #1;
      exp_id = -1;
      for (int i = 0; i < NREQ; i++)
        if (exp_id < 0 && r_v[(exp_ptr + i) % NREQ]) exp_id = (exp_ptr + i) % NREQ;
      if (exp_id < 0) begin
        chk("no_request_pending", 32'd0, 32'd1);
        return;
      end
      waited = 0;
      while (req_ready == '0 && waited < 200) begin @(negedge clk); waited++; end
      chk("grant_timeout", 32'(waited < 200), 32'd1);
      if (waited >= 200) return;
      chk("grant_onehot", 32'(req_ready), 32'(1 << exp_id));
      g = cyc;
      lat = $urandom_range(0, 6);
      model_lat = lat;
      sgn = ~r_op[exp_id][0];
      special = (r_b[exp_id] == 0) || (sgn && r_a[exp_id] == INT_MIN && r_b[exp_id] == 32'hFFFF_FFFF);
      exp_res = div_calc(sgn, r_a[exp_id], r_b[exp_id], r_op[exp_id][1]);
      exp_tag = r_tag[exp_id];
      s0 = start_count;
      last_gid = exp_id;
      gq.push_back(exp_id);
      exp_ptr = (exp_id + 1) % NREQ;
      @(posedge clk); #1;
      if (refill > 0) begin rand_req(exp_id); refill--; end
      else r_v[exp_id] = 1'b0;
      rsp_ready = (stall == 0);
      waited = 0;
      @(negedge clk);
      while (!rsp_valid && waited < 300) begin
        chk("no_grant_outside_idle", 32'(req_ready), 32'd0);
        @(negedge clk); waited++;
      end
      chk("rsp_timeout", 32'(rsp_valid), 32'd1);
      if (!rsp_valid) return;
      chk("rsp_latency", 32'(cyc - g), special ? 32'd1 : 32'(3 + SG + lat));
      chk("rsp_data", rsp_data, exp_res);
      chk("rsp_id", 32'(rsp_id), 32'(exp_id));
      chk("rsp_tag", 32'(rsp_tag), 32'(exp_tag));
      chk("div_start_count", 32'(start_count - s0), special ? 32'd0 : 32'd1);
      last_data = rsp_data;
      hold_d = rsp_data;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk("stall_valid", 32'(rsp_valid), 32'd1);
        chk("stall_data", rsp_data, hold_d);
        chk("stall_id", 32'(rsp_id), 32'(exp_id));
        chk("stall_tag", 32'(rsp_tag), 32'(exp_tag));
        chk("stall_no_grant", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("rsp_drop", 32'(rsp_valid), 32'd0);
    end
  endtask

  initial begin
    int waited, g;
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited, g, s0;
    for (int i = 0; i < NREQ; i++) begin
      r_v[i] = 1'b0; r_op[i] = '0; r_a[i] = '0; r_b[i] = '0; r_tag[i] = '0;
    end
    rsp_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_ptr = 0;
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_div_start", 32'(div_start), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("reset_div_a", div_a, 32'd0);
    chk("reset_div_b", div_b, 32'd0);
    chk("reset_div_signed", 32'(div_signed), 32'd0);
    @(negedge clk);

    set_req(0, OP_DIV, 32'd100, 32'd7, 5'd3);
    run_ops(1, 0, 0);
    chk("t1_value", last_data, 32'd14);
    chk("t1_id", 32'(last_gid), 32'd0);

    set_req(1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7);
    run_ops(1, 0, 0);
    chk("t2_div_value", last_data, 32'hFFFF_FFFD);
    set_req(0, OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd8);
    run_ops(1, 0, 0);
    chk("t2_rem_value", last_data, 32'hFFFF_FFFF);

    set_req(1, OP_DIVU, 32'h1234, 32'd0, 5'd9);
    run_ops(1, 0, 0);
    chk("t3_divu_zero", last_data, 32'hFFFF_FFFF);
    set_req(0, OP_REMU, 32'h1234, 32'd0, 5'd10);
    run_ops(1, 0, 0);
    chk("t3_remu_zero", last_data, 32'h1234);

    set_req(1, OP_DIV, INT_MIN, 32'hFFFF_FFFF, 5'd11);
    run_ops(1, 0, 0);
    chk("t4_div_ovf", last_data, 32'h8000_0000);
    set_req(0, OP_REM, INT_MIN, 32'hFFFF_FFFF, 5'd12);
    run_ops(1, 0, 0);
    chk("t4_rem_ovf", last_data, 32'h0);
    set_req(1, OP_DIVU, INT_MIN, 32'hFFFF_FFFF, 5'd13);
    run_ops(1, 0, 0);
    chk("t4_divu_ovf_operands", last_data, 32'h0);

    gq.delete();
    rand_req(0);
    rand_req(1);
    run_ops(4, 0, 2);
    chk("t5_grant_count", 32'(gq.size()), 32'd4);
    for (int i = 0; i < gq.size(); i++) chk("t5_grant_order", 32'(gq[i]), 32'(i % 2));

    rand_req(0);
    rand_req(1);
    run_ops(1, 10, 0);
    run_ops(1, 0, 0);

    #1;
    set_req(0, OP_DIVU, 32'd1000, 32'd3, 5'd21);
    model_lat = 30;
    waited = 0;
    while (req_ready == '0 && waited < 50) begin @(negedge clk); waited++; end
    chk("t7_grant_timeout", 32'(waited < 50), 32'd1);
    s0 = start_count;
    @(posedge clk); #1;
    set_req(0, OP_DIV, 32'd50, 32'hFFFF_FFFB, 5'd22);
    repeat (5) @(negedge clk);
    chk("t7_started", 32'(start_count - s0), 32'd1);
    reset = 1'b1;
    #1;
    chk("t7_no_grant_in_reset", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_ptr = 0;
    #1;
    chk("t7_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t7_div_start", 32'(div_start), 32'd0);
    chk("t7_rsp_data", rsp_data, 32'd0);
    chk("t7_busy_grant", 32'(req_ready), 32'd0);
    waited = 0;
    while (div_busy && waited < 100) begin
      chk("t7_no_grant_busy", 32'(req_ready), 32'd0);
      chk("t7_no_rsp_busy", 32'(rsp_valid), 32'd0);
      @(negedge clk); waited++;
    end
    chk("t7_busy_timeout", 32'(waited < 100), 32'd1);
    run_ops(1, 0, 0);
    chk("t7_after_reset_value", last_data, 32'hFFFF_FFF6);

    for (int n = 0; n < 20; n++) begin
      int mask;
      mask = $urandom_range(1, 3);
      for (int i = 0; i < NREQ; i++) begin
        if (mask[i]) rand_req(i);
        else r_v[i] = 1'b0;
      end
      run_ops(1, $urandom_range(0, 2), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
